// File: rtl/seg7_scan_ctrl_if.sv
// Bus between user logic and the 4-digit 7-segment scan controller.
// The master side supplies the display value; the slave side drives the display pins.
interface seg7_scan_ctrl_if;
  logic [15:0] x;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  modport master (
    output x, dp_in, load, lz_en,
    input  a_to_g, dp, an, pending, frame_tick
  );

  modport slave (
    input  x, dp_in, load, lz_en,
    output a_to_g, dp, an, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blank gaps
// between digits and frame-aligned (tear-free) display updates.
module seg7_scan_ctrl #(
  parameter int DIG_CYC = 50000,
  parameter int GAP_CYC = 500,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            clr,
  seg7_scan_ctrl_if.slave bus
);

  typedef enum logic {SHOW, GAP} state_t;

  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t           state, state_n;
  logic [1:0]       digit, digit_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      disp, disp_n, pend;
  logic [3:0]       disp_dp, disp_dp_n, pend_dp;
  logic             boundary;
  logic [6:0]       seg_n;
  logic [3:0]       an_n;
  logic             dp_n;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // A digit is blanked when it and every more significant nibble are zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
    case (d)
      2'd1:    return v[15:4] == 12'h000;
      2'd2:    return v[15:8] == 8'h00;
      2'd3:    return v[15:12] == 4'h0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    digit_n  = digit;
    cnt_n    = cnt + 1'b1;
    boundary = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == DIG_LAST) begin
          cnt_n = '0;
          if (GAP_CYC == 0) begin
            digit_n  = digit + 2'd1;
            boundary = (digit == 2'd3);
          end else begin
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n    = '0;
          state_n  = SHOW;
          digit_n  = digit + 2'd1;
          boundary = (digit == 2'd3);
        end
      end
    endcase

    // The pending value lands on the wrap edge so the new frame starts clean.
    disp_n    = (boundary && bus.pending) ? pend : disp;
    disp_dp_n = (boundary && bus.pending) ? pend_dp : disp_dp;

    an_n  = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (state_n == SHOW && !(bus.lz_en && lz_blank(disp_n, digit_n))) begin
      an_n  = ~(4'b0001 << digit_n);
      seg_n = hex_seg(disp_n[{digit_n, 2'b00} +: 4]);
      dp_n  = ~disp_dp_n[digit_n];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= SHOW;
      digit          <= 2'd0;
      cnt            <= '0;
      disp           <= 16'h0000;
      disp_dp        <= 4'h0;
      pend           <= 16'h0000;
      pend_dp        <= 4'h0;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.a_to_g     <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.an         <= 4'hF;
    end else begin
      state          <= state_n;
      digit          <= digit_n;
      cnt            <= cnt_n;
      disp           <= disp_n;
      disp_dp        <= disp_dp_n;
      bus.frame_tick <= boundary;
      bus.a_to_g     <= seg_n;
      bus.dp         <= dp_n;
      bus.an         <= an_n;
      // A load on the wrap edge re-arms pending with the fresh value.
      if (bus.load) begin
        pend        <= bus.x;
        pend_dp     <= bus.dp_in;
        bus.pending <= 1'b1;
      end else if (boundary) begin
        bus.pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (with and without blank gaps) checked
// every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int DIG = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] in_x = '0;
  logic [3:0]  in_dp = '0;
  logic        in_load = 1'b0;
  logic        in_lz = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if ifa ();
  seg7_scan_ctrl_if ifb ();

  assign ifa.x = in_x;
  assign ifa.dp_in = in_dp;
  assign ifa.load = in_load;
  assign ifa.lz_en = in_lz;
  assign ifb.x = in_x;
  assign ifb.dp_in = in_dp;
  assign ifb.load = in_load;
  assign ifb.lz_en = in_lz;

  seg7_scan_ctrl #(.DIG_CYC(DIG), .GAP_CYC(1), .CNT_W(4)) dut_a (.clk(clk), .clr(clr), .bus(ifa));
  seg7_scan_ctrl #(.DIG_CYC(DIG), .GAP_CYC(0), .CNT_W(4)) dut_b (.clk(clk), .clr(clr), .bus(ifb));

  // Reference model state, one slot per instance.
  logic [6:0]  seg_tab [16];
  int          gapc [2];
  int          n [2];
  logic [15:0] disp [2];
  logic [15:0] pend [2];
  logic [3:0]  ddp [2];
  logic [3:0]  pdp [2];
  logic        pnd [2];
  logic        lz_edge;

  function automatic int slot_len(input int k);
    return DIG + gapc[k];
  endfunction

  function automatic int frame_len(input int k);
    return 4 * slot_len(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; disp[k] = '0; pend[k] = '0; ddp[k] = '0; pdp[k] = '0; pnd[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!clr) begin
      lz_edge = in_lz;
      for (int k = 0; k < 2; k++) begin
        n[k]++;
        if ((n[k] % frame_len(k)) == 0 && pnd[k]) begin
          disp[k] = pend[k]; ddp[k] = pdp[k]; pnd[k] = 1'b0;
        end
        if (in_load) begin
          pend[k] = in_x; pdp[k] = in_dp; pnd[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s inst=%0d n=%0d observed=%h expected=%h", tag, k, n[k], obs, expv);
    end
  endtask

  task automatic check_one(input int k, input logic [3:0] o_an, input logic [6:0] o_seg,
                           input logic o_dp, input logic o_pnd, input logic o_ft);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft, blank;
    logic [15:0] hi;
    int ph, dg, off;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    ph = n[k] % frame_len(k);
    dg = ph / slot_len(k);
    off = ph % slot_len(k);
    if (n[k] > 0) begin
      e_ft = (ph == 0);
      hi = disp[k] >> (4 * dg);
      blank = lz_edge && (dg > 0) && (hi == 16'h0);
      if (off < DIG && !blank) begin
        e_an = ~(4'b0001 << dg);
        e_seg = seg_tab[hi[3:0]];
        e_dp = ~ddp[k][dg];
      end
    end
    chk("an", k, {12'h0, o_an}, {12'h0, e_an});
    chk("a_to_g", k, {9'h0, o_seg}, {9'h0, e_seg});
    chk("dp", k, {15'h0, o_dp}, {15'h0, e_dp});
    chk("pending", k, {15'h0, o_pnd}, {15'h0, pnd[k]});
    chk("frame_tick", k, {15'h0, o_ft}, {15'h0, e_ft});
  endtask

  task automatic check_all();
    check_one(0, ifa.an, ifa.a_to_g, ifa.dp, ifa.pending, ifa.frame_tick);
    check_one(1, ifb.an, ifb.a_to_g, ifb.dp, ifb.pending, ifb.frame_tick);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    in_x = v; in_dp = d; in_load = 1'b1;
    cycle();
    in_load = 1'b0;
  endtask

  // Step until instance k sits at frame position ph (bounded).
  task automatic advance_to(input int k, input int ph);
    int guard;
    guard = 0;
    while ((n[k] % frame_len(k)) != ph && guard < 200) begin
      cycle();
      guard++;
    end
    tests++;
    assert ((n[k] % frame_len(k)) == ph) else begin
      fails++;
      $error("FAIL advance_to inst=%0d observed_pos=%0d expected_pos=%0d", k, n[k] % frame_len(k), ph);
    end
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    gapc = '{1, 0};
    lz_edge = 1'b0;
    model_reset();

    // Held in reset; a load strobe here must be ignored.
    cycle();
    in_x = 16'hBEEF; in_load = 1'b1;
    cycle();
    in_load = 1'b0;
    clr = 1'b0;

    // First frame and the wrap tick.
    run(22);

    // Tear-free load issued mid digit 1.
    advance_to(0, 6);
    load_val(16'h1A3F, 4'h0);
    run(40);

    // Leading-zero suppression.
    in_lz = 1'b1;
    load_val(16'h0045, 4'h0);
    run(44);
    load_val(16'h0000, 4'h0);
    run(44);
    in_lz = 1'b0;

    // Overwrite inside a frame, then a load on the wrap edge itself.
    advance_to(0, 2);
    load_val(16'h1111, 4'h0);
    run(3);
    load_val(16'h2222, 4'h0);
    advance_to(0, 19);
    load_val(16'h3333, 4'h0);
    run(45);

    // Decimal points.
    load_val(16'h8888, 4'b0101);
    run(42);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_x = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h00FF);
      in_dp = 4'($urandom);
      in_load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 29) == 0) in_lz = ~in_lz;
      cycle();
    end
    in_load = 1'b0;

    // Asynchronous reset in the middle of digit 2 while a value is pending.
    advance_to(0, 10);
    load_val(16'h5A5A, 4'hF);
    cycle();
    #2 clr = 1'b1;
    model_reset();
    #1 check_all();
    cycle();
    clr = 1'b0;
    run(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
